// File: rtl/corefifo_rd_ptr_ctrl_pkg.sv
// Shared FIFO pointer helpers used by both read- and write-side controllers.
// Pointers carry one extra bit so full and empty stay distinguishable.
package corefifo_rd_ptr_ctrl_pkg;

    localparam int PTR_MAX = 32;

    function automatic int ptr_width(input int aw);
        return aw + 1;
    endfunction

    function automatic logic [PTR_MAX-1:0] bin2gray(input logic [PTR_MAX-1:0] b);
        return b ^ (b >> 1);
    endfunction

endpackage

// File: rtl/corefifo_rd_ptr_ctrl_gray2bin.sv
// Gray-to-binary pointer converter shared by the FIFO pointer controllers.
module corefifo_grayToBinConv #(
    parameter int ADDRWIDTH = 3
) (
    input  logic [ADDRWIDTH:0] gray,
    output logic [ADDRWIDTH:0] bin
);

    always_comb begin
        bin = '0;
        for (int i = 0; i <= ADDRWIDTH; i++) begin
            bin[i] = ^(gray >> i);
        end
    end

endmodule

// File: rtl/corefifo_rd_ptr_ctrl.sv
// CoreFIFO read-side pointer controller: write-pointer sync, read pointer,
// fill count, empty/almost-empty, underflow and read-data-valid.
module corefifo_rd_ptr_ctrl
    import corefifo_rd_ptr_ctrl_pkg::*;
#(
    parameter int ADDRWIDTH = 3,
    parameter int AE_THRESH = 1
) (
    input  logic                 rclk,
    input  logic                 rrst,
    input  logic [ADDRWIDTH:0]   wptr_gray_in,
    input  logic                 re,
    output logic [ADDRWIDTH-1:0] raddr,
    output logic                 rd_mem_en,
    output logic [ADDRWIDTH:0]   rptr_gray_out,
    output logic                 empty,
    output logic                 aempty,
    output logic [ADDRWIDTH:0]   rdcnt,
    output logic                 underflow,
    output logic                 dvld
);

    localparam int PW = ptr_width(ADDRWIDTH);
    localparam logic [PW-1:0] AE = PW'(AE_THRESH);

    logic [PW-1:0] s1;
    logic [PW-1:0] s2;
    logic [PW-1:0] wbin;
    logic [PW-1:0] rptr_bin;
    logic [PW-1:0] rptr_next;
    logic [PW-1:0] cnt_next;
    logic          rd_ok;

    corefifo_grayToBinConv #(
        .ADDRWIDTH(ADDRWIDTH)
    ) u_g2b (
        .gray(s2),
        .bin (wbin)
    );

    assign rd_ok     = re & ~empty;
    assign rd_mem_en = rd_ok;
    assign rptr_next = rptr_bin + PW'(rd_ok);
    // Full-width subtraction keeps the count right across the pointer wrap.
    assign cnt_next  = wbin - rptr_next;
    assign raddr     = rptr_bin[ADDRWIDTH-1:0];

    always_ff @(posedge rclk) begin
        if (rrst) begin
            s1            <= '0;
            s2            <= '0;
            rptr_bin      <= '0;
            rptr_gray_out <= '0;
            rdcnt         <= '0;
            empty         <= 1'b1;
            aempty        <= 1'b1;
            underflow     <= 1'b0;
            dvld          <= 1'b0;
        end else begin
            s1            <= wptr_gray_in;
            s2            <= s1;
            rptr_bin      <= rptr_next;
            rptr_gray_out <= PW'(bin2gray(PTR_MAX'(rptr_next)));
            rdcnt         <= cnt_next;
            empty         <= (cnt_next == '0);
            aempty        <= (cnt_next <= AE);
            underflow     <= re & empty;
            dvld          <= rd_ok;
        end
    end

endmodule

// File: tb/tb_corefifo_rd_ptr_ctrl.sv
// Bench for corefifo_rd_ptr_ctrl: vector table, hand sequences and
// randomized traffic against a word-count reference model.
module tb_corefifo_rd_ptr_ctrl;

    localparam int AW = 3;
    localparam int AE_T = 1;
    localparam int DEPTH = 1 << AW;
    localparam int MOD = 2 * DEPTH;

    logic          clk;
    logic          rst;
    logic [AW:0]   wgray;
    logic          re;
    logic [AW-1:0] raddr;
    logic          rd_mem_en;
    logic [AW:0]   rgray;
    logic          empty;
    logic          aempty;
    logic [AW:0]   rdcnt;
    logic          underflow;
    logic          dvld;

    int n_chk;
    int n_fail;
    int wv;

    corefifo_rd_ptr_ctrl #(
        .ADDRWIDTH(AW),
        .AE_THRESH(AE_T)
    ) dut (
        .rclk         (clk),
        .rrst         (rst),
        .wptr_gray_in (wgray),
        .re           (re),
        .raddr        (raddr),
        .rd_mem_en    (rd_mem_en),
        .rptr_gray_out(rgray),
        .empty        (empty),
        .aempty       (aempty),
        .rdcnt        (rdcnt),
        .underflow    (underflow),
        .dvld         (dvld)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: write/read positions as plain counts modulo 2*DEPTH,
    // with the write count seen two cycles late.
    int m_d1, m_d2, m_rp, m_cnt;
    bit m_empty, m_ae, m_uf, m_dv;

    initial begin
        m_d1 = 0; m_d2 = 0; m_rp = 0; m_cnt = 0;
        m_empty = 1; m_ae = 1; m_uf = 0; m_dv = 0;
    end

    always @(posedge clk) begin
        bit ok;
        if (rst) begin
            m_d1 = 0; m_d2 = 0; m_rp = 0; m_cnt = 0;
            m_empty = 1; m_ae = 1; m_uf = 0; m_dv = 0;
        end else begin
            ok = re && !m_empty;
            m_uf = re && m_empty;
            m_dv = ok;
            m_rp = (m_rp + int'(ok)) % MOD;
            m_cnt = (m_d2 - m_rp + MOD) % MOD;
            m_empty = (m_cnt == 0);
            m_ae = (m_cnt <= AE_T);
            m_d2 = m_d1;
            m_d1 = wv;
        end
    end

    always @(negedge clk) begin
        chk("m_empty", 32'(empty), 32'(m_empty));
        chk("m_aempty", 32'(aempty), 32'(m_ae));
        chk("m_rdcnt", 32'(rdcnt), 32'(m_cnt));
        chk("m_raddr", 32'(raddr), 32'(m_rp % DEPTH));
        chk("m_rgray", 32'(rgray), 32'(m_rp ^ (m_rp >> 1)));
        chk("m_underflow", 32'(underflow), 32'(m_uf));
        chk("m_dvld", 32'(dvld), 32'(m_dv));
        chk("m_rd_mem_en", 32'(rd_mem_en), 32'(re && !m_empty));
        chk("m_cnt_le_depth", 32'(rdcnt <= DEPTH), 32'd1);
    end

    task automatic step(input bit r, input int w, input bit rd);
        rst = r;
        wv = w;
        wgray = (AW+1)'(w ^ (w >> 1));
        re = rd;
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        bit rst;
        int w;
        bit re;
        bit e_empty;
        bit e_ae;
        int e_cnt;
        int e_raddr;
        bit e_uf;
        bit e_dv;
    } vec_t;

    vec_t vq[$];

    task automatic add(input bit r, input int w, input bit rd, input bit e,
                       input bit ae, input int c, input int ra, input bit uf,
                       input bit dv);
        vec_t v;
        v.rst = r; v.w = w; v.re = rd; v.e_empty = e; v.e_ae = ae;
        v.e_cnt = c; v.e_raddr = ra; v.e_uf = uf; v.e_dv = dv;
        vq.push_back(v);
    endtask

    initial begin
        n_chk = 0;
        n_fail = 0;
        rst = 1'b1;
        wv = 0;
        wgray = '0;
        re = 1'b1;

        // reset with re held high
        add(1, 0, 1, 1, 1, 0, 0, 0, 0);
        add(1, 0, 1, 1, 1, 0, 0, 0, 0);
        // single write, empty falls at the third edge
        add(0, 1, 0, 1, 1, 0, 0, 0, 0);
        add(0, 1, 0, 1, 1, 0, 0, 0, 0);
        add(0, 1, 0, 0, 1, 1, 0, 0, 0);
        add(0, 1, 1, 1, 1, 0, 1, 0, 1);
        add(0, 1, 0, 1, 1, 0, 1, 0, 0);
        // read while empty
        add(0, 1, 1, 1, 1, 0, 1, 1, 0);
        add(0, 1, 0, 1, 1, 0, 1, 0, 0);
        // fill to 8
        add(0, 9, 0, 1, 1, 0, 1, 0, 0);
        add(0, 9, 0, 1, 1, 0, 1, 0, 0);
        add(0, 9, 0, 0, 0, 8, 1, 0, 0);
        // drain back to back
        for (int k = 1; k <= 8; k++) begin
            add(0, 9, 1, (8 - k) == 0, (8 - k) <= AE_T, 8 - k,
                (1 + k) % DEPTH, 0, 1);
        end
        add(0, 9, 1, 1, 1, 0, 1, 1, 0);
        // read racing a newly arriving write keeps count 1
        add(0, 10, 0, 1, 1, 0, 1, 0, 0);
        add(0, 10, 0, 1, 1, 0, 1, 0, 0);
        add(0, 10, 0, 0, 1, 1, 1, 0, 0);
        add(0, 11, 0, 0, 1, 1, 1, 0, 0);
        add(0, 11, 0, 0, 1, 1, 1, 0, 0);
        add(0, 11, 1, 0, 1, 1, 2, 0, 1);

        for (int i = 0; i < vq.size(); i++) begin
            step(vq[i].rst, vq[i].w, vq[i].re);
            chk($sformatf("v%0d empty", i), 32'(empty), 32'(vq[i].e_empty));
            chk($sformatf("v%0d aempty", i), 32'(aempty), 32'(vq[i].e_ae));
            chk($sformatf("v%0d rdcnt", i), 32'(rdcnt), 32'(vq[i].e_cnt));
            chk($sformatf("v%0d raddr", i), 32'(raddr), 32'(vq[i].e_raddr));
            chk($sformatf("v%0d underflow", i), 32'(underflow), 32'(vq[i].e_uf));
            chk($sformatf("v%0d dvld", i), 32'(dvld), 32'(vq[i].e_dv));
        end

        // reset in the middle of a drain
        step(1, 0, 0);
        step(0, 5, 0);
        step(0, 5, 0);
        step(0, 5, 0);
        chk("md count5", 32'(rdcnt), 32'd5);
        step(0, 5, 1);
        chk("md read dvld", 32'(dvld), 32'd1);
        chk("md read cnt", 32'(rdcnt), 32'd4);
        step(1, 5, 1);
        chk("md rst empty", 32'(empty), 32'd1);
        chk("md rst aempty", 32'(aempty), 32'd1);
        chk("md rst rdcnt", 32'(rdcnt), 32'd0);
        chk("md rst raddr", 32'(raddr), 32'd0);
        chk("md rst rgray", 32'(rgray), 32'd0);
        chk("md rst uf", 32'(underflow), 32'd0);
        chk("md rst dvld", 32'(dvld), 32'd0);
        step(0, 5, 1);
        chk("md post dvld", 32'(dvld), 32'd0);
        chk("md post rdcnt", 32'(rdcnt), 32'd0);

        // randomized traffic with pointer wraps
        step(1, 0, 0);
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 80) == 0) begin
                step(1, 0, 0);
            end else begin
                if ($urandom_range(0, 1) == 1 && ((wv - m_rp + MOD) % MOD) < DEPTH)
                    wv = (wv + 1) % MOD;
                step(0, wv, 1'($urandom_range(0, 1)));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/corefifo_rd_ptr_ctrl.md
# corefifo_rd_ptr_ctrl

Read-side pointer and flag controller for the CoreFIFO read port. Takes the Gray-coded write pointer from the write domain and synchronises it with two flops. Converts it to binary with the shared Gray-to-binary converter, then maintains the binary/Gray read pointer, RAM read address, empty/almost-empty flags, fill count, underflow and read-data-valid. Sits between the write-pointer crossing and the FIFO RAM read port.

## Interface
Parameters:
- ADDRWIDTH, 3, RAM address width; depth = 2^ADDRWIDTH, pointers are ADDRWIDTH+1 bits
- AE_THRESH, 1, almost-empty threshold in words (0 .. 2^ADDRWIDTH)

Ports:
- rclk  in  1  read-domain clock; all logic is on its rising edge
- rrst  in  1  reset, synchronous, active-high
- wptr_gray_in  in  ADDRWIDTH+1  write pointer, Gray code, from write domain (asynchronous to rclk)
- re  in  1  read request
- raddr  out  ADDRWIDTH  RAM read address = rptr_bin[ADDRWIDTH-1:0]
- rd_mem_en  out  1  RAM read strobe = re & ~empty (combinational)
- rptr_gray_out  out  ADDRWIDTH+1  registered Gray read pointer, to write domain
- empty  out  1  registered; FIFO empty
- aempty  out  1  registered; count <= AE_THRESH
- rdcnt  out  ADDRWIDTH+1  registered fill count, 0 .. 2^ADDRWIDTH
- underflow  out  1  registered one-cycle pulse on a rejected read
- dvld  out  1  registered; RAM output valid (RAM read latency 1)

## Operation
- Sync: s1 <= wptr_gray_in; s2 <= s1. s2 feeds the converter: wbin = gray2bin(s2).
- Accept: rd_ok = re & ~empty.
  - rptr_next = rptr_bin + rd_ok, modulo 2^(ADDRWIDTH+1).
  - rptr_bin <= rptr_next.
  - rptr_gray_out <= rptr_next ^ (rptr_next >> 1).
- Count: cnt_next = (wbin - rptr_next) mod 2^(ADDRWIDTH+1). rdcnt <= cnt_next.
  - Values above 2^ADDRWIDTH are not produced by a legal write side and are not checked.
- Flags: empty <= (cnt_next == 0); aempty <= (cnt_next <= AE_THRESH).
- underflow <= re & empty. The pointer holds and RAM is not strobed.
- dvld <= rd_ok.
- Wrap-around: the pointer MSB toggles each full lap. Empty/count use the full ADDRWIDTH+1 bits, so they stay correct across the wrap (e.g. wbin=1, rptr=15, ADDRWIDTH=3 gives count 2).
- Reset values, all outputs and state:
  - s1, s2, rptr_bin, rptr_gray_out, raddr, rdcnt = 0
  - empty = 1, aempty = 1
  - underflow = 0, dvld = 0
- Reset dominates re. A reset asserted mid-drain clears everything on that edge, and no dvld follows it.
- Simultaneous read and write-pointer arrival: the count reflects both in the same update (e.g. count 1, re=1, new write arriving in s2 keeps count 1 and empty 0).

## Timing
- wptr_gray_in change to empty/rdcnt update: third rclk edge (s1, s2, flag register).
- Read accepted at edge k: rptr/raddr/rptr_gray_out/rdcnt/empty update at edge k; dvld high in cycle k+1 to k+2.
- Last word: with count 1 and re=1, empty rises at the accepting edge, so a back-to-back re in the next cycle is rejected and flagged as underflow.
- Sustained re with data available: one word per cycle, no bubbles.
- rd_mem_en is combinational from re and registered empty; no other combinational input-to-output path.

## Structure
- Shared package/include: pointer width (ADDRWIDTH+1) and the bin-to-Gray function. The same package is used by the write-side controller.
- One sub-module: the existing corefifo_grayToBinConv, instantiated on s2 with matching ADDRWIDTH.
- Everything else is inline: sync flops, pointer register, count/flag logic. Target 150–250 lines.

## Test plan
- Reset: hold rrst 2 cycles with re=1 -> empty=1, aempty=1, rdcnt=0, raddr=0, rptr_gray_out=0, underflow=0, dvld=0.
- Single write: wptr_gray_in 0->1 -> empty falls at the third edge and rdcnt=1. Then re for one cycle -> raddr 0->1, rptr_gray_out=1, dvld one cycle later, empty=1 again.
- Full then drain (ADDRWIDTH=3, AE_THRESH=1): wptr Gray for 8 -> rdcnt=8, aempty=0. Eight back-to-back reads -> rdcnt 7..0, aempty rises at count 1, 8 dvld pulses, no underflow.
- Wrap: step the write pointer through 16 Gray values with interleaved reads -> rptr wraps 15->0, rptr_gray_out matches bin^(bin>>1) at every step, and count never exceeds 8.
- Underflow: re=1 with empty=1 -> underflow pulse the next cycle, rd_mem_en=0, pointer unchanged, dvld=0.
- Reset mid-drain: count 5, re=1, assert rrst -> all outputs at reset values on that edge, and no dvld in the following cycle.
